// File: rtl/prio_irq_encoder_if.sv
// Request/acknowledge bundle for prio_irq_encoder.
// The event source and consumer side (master) drives req, mask and ack.
// The encoder side (slave) returns irq, code and pending.
interface prio_irq_encoder_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
);
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         ack;
  logic         irq;
  logic [W-1:0] code;
  logic [N-1:0] pending;

  modport master (
    output req,
    output mask,
    output ack,
    input  irq,
    input  code,
    input  pending
  );

  modport slave (
    input  req,
    input  mask,
    input  ack,
    output irq,
    output code,
    output pending
  );
endinterface

// File: rtl/prio_irq_encoder.sv
// Registered N-line priority encoder with rising-edge request capture,
// masking and an acknowledge handshake. A presented code is held until
// it is acknowledged.
// Optional build macro PRIO_IRQ_ROTATE_EN selects round-robin priority.
// Without it, the highest unmasked pending index always wins.
module prio_irq_encoder #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input logic                clk,
  input logic                rst,
  prio_irq_encoder_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] req_d_q;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic [N-1:0] events;
  logic [N-1:0] eligible;
  logic [N-1:0] clr;
  logic [W-1:0] winner;
  logic         any_eligible;

  assign events       = bus.req & ~req_d_q;
  assign eligible     = pending_q & ~bus.mask;
  assign any_eligible = |eligible;

`ifdef PRIO_IRQ_ROTATE_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Round-robin search: start just below the last served line and descend with wrap.
  always_comb begin
    logic         found;
    int           idx;
    logic [N-1:0] elig_sh;
    winner  = '0;
    found   = 1'b0;
    idx     = 0;
    elig_sh = '0;
    for (int j = 0; j < int'(N); j++) begin
      idx     = (int'(ptr_q) + int'(N) - 1 - j) % int'(N);
      elig_sh = eligible >> idx;
      if (!found && elig_sh[0]) begin
        found  = 1'b1;
        winner = W'(idx);
      end
    end
  end
`else
  // Fixed priority: the highest set eligible index wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (eligible[i]) winner = W'(i);
    end
  end
`endif

  // Next-state logic: FSM, code latch, pending clear on ack.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    clr     = '0;
`ifdef PRIO_IRQ_ROTATE_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_eligible) begin
          code_d  = winner;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (bus.ack) begin
          clr     = N'(1) << code_q;
          state_d = StIdle;
`ifdef PRIO_IRQ_ROTATE_EN
          ptr_d   = code_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    // A new edge on the line being cleared keeps it pending.
    pending_d = (pending_q & ~clr) | events;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      req_d_q   <= '0;
      pending_q <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_d_q   <= bus.req;
      pending_q <= pending_d;
      code_q    <= code_d;
    end
  end

`ifdef PRIO_IRQ_ROTATE_EN
  // Round-robin pointer: last acknowledged code.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign bus.irq     = (state_q == StBusy);
  assign bus.code    = code_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Directed self-checking bench for prio_irq_encoder (N = 8, W = 3).
module tb_prio_irq_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  prio_irq_encoder_if #(.N(8), .W(3)) bus ();

  prio_irq_encoder #(.N(8), .W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.mask = '0; bus.ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 8'hFF; bus.mask = '0; bus.ack = 1'b0;
    tick(); tick();
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", bus.irq); end
    checks++; if (bus.code !== 3'd0) begin errors++; $display("FAIL rst_code got %0d exp 0", bus.code); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL rst_pending got %h exp 00", bus.pending); end
    rst = 1'b0;
    tick();
    checks++; if (bus.pending !== 8'hFF) begin errors++; $display("FAIL rst_held_pending got %h exp ff", bus.pending); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_held_irq0 got %b exp 0", bus.irq); end
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd7) begin
      errors++; $display("FAIL rst_first_code got irq=%b code=%0d exp irq=1 code=7", bus.irq, bus.code);
    end
    // Reset while busy with ack asserted: everything clears.
    rst = 1'b1; bus.ack = 1'b1; bus.req = '0;
    tick();
    checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h00 || bus.code !== 3'd0) begin
      errors++; $display("FAIL rst_mid_busy got irq=%b pend=%h code=%0d exp 0 00 0", bus.irq, bus.pending, bus.code);
    end
    bus.ack = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 8'h20;
    tick();
    checks++; if (bus.pending !== 8'h20 || bus.irq !== 1'b0) begin
      errors++; $display("FAIL single_pend got pend=%h irq=%b exp 20 0", bus.pending, bus.irq);
    end
    bus.req = '0;
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd5) begin
      errors++; $display("FAIL single_code got irq=%b code=%0d exp 1 5", bus.irq, bus.code);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h00) begin
      errors++; $display("FAIL single_ack got irq=%b pend=%h exp 0 00", bus.irq, bus.pending);
    end
  endtask

  task automatic test_mask();
    do_reset();
    bus.mask = 8'h40; bus.req = 8'h54;
    tick();
    bus.req = '0;
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd4) begin
      errors++; $display("FAIL mask_first got irq=%b code=%0d exp 1 4", bus.irq, bus.code);
    end
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd4) begin
      errors++; $display("FAIL mask_hold got irq=%b code=%0d exp 1 4", bus.irq, bus.code);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h44) begin
      errors++; $display("FAIL mask_ack1 got irq=%b pend=%h exp 0 44", bus.irq, bus.pending);
    end
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd2) begin
      errors++; $display("FAIL mask_second got irq=%b code=%0d exp 1 2", bus.irq, bus.code);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h40) begin
      errors++; $display("FAIL mask_masked_idle got irq=%b pend=%h exp 0 40", bus.irq, bus.pending);
    end
    bus.mask = '0;
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd6) begin
      errors++; $display("FAIL mask_unmask got irq=%b code=%0d exp 1 6", bus.irq, bus.code);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL mask_drain got %h exp 00", bus.pending); end
  endtask

  task automatic test_hold();
    do_reset();
    bus.req = 8'h04;
    tick();
    bus.req = '0;
    tick();
    bus.req = 8'h80;
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd2 || bus.pending !== 8'h84) begin
      errors++; $display("FAIL hold_newreq got irq=%b code=%0d pend=%h exp 1 2 84", bus.irq, bus.code, bus.pending);
    end
    bus.mask = 8'hFF;
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd2) begin
      errors++; $display("FAIL hold_maskchg got irq=%b code=%0d exp 1 2", bus.irq, bus.code);
    end
    bus.mask = '0; bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h80) begin
      errors++; $display("FAIL hold_gap got irq=%b pend=%h exp 0 80", bus.irq, bus.pending);
    end
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd7) begin
      errors++; $display("FAIL hold_next got irq=%b code=%0d exp 1 7", bus.irq, bus.code);
    end
    bus.ack = 1'b1; bus.req = '0;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic test_collision();
    do_reset();
    bus.req = 8'h08;
    tick();
    bus.req = '0;
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd3) begin
      errors++; $display("FAIL coll_first got irq=%b code=%0d exp 1 3", bus.irq, bus.code);
    end
    bus.ack = 1'b1; bus.req = 8'h08;
    tick();
    bus.ack = 1'b0; bus.req = '0;
    checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h08) begin
      errors++; $display("FAIL coll_setwins got irq=%b pend=%h exp 0 08", bus.irq, bus.pending);
    end
    tick();
    checks++; if (bus.irq !== 1'b1 || bus.code !== 3'd3) begin
      errors++; $display("FAIL coll_repres got irq=%b code=%0d exp 1 3", bus.irq, bus.code);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL coll_drain got %h exp 00", bus.pending); end
  endtask

  task automatic test_ack_idle();
    do_reset();
    bus.req = 8'h02; bus.mask = 8'h02;
    tick();
    bus.req = '0; bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    checks++; if (bus.irq !== 1'b0 || bus.pending !== 8'h02) begin
      errors++; $display("FAIL ack_idle got irq=%b pend=%h exp 0 02", bus.irq, bus.pending);
    end
    bus.mask = '0;
  endtask

  task automatic test_rotate();
    logic [2:0] exp_codes [6];
`ifdef PRIO_IRQ_ROTATE_EN
    exp_codes = '{3'd6, 3'd5, 3'd1, 3'd6, 3'd5, 3'd1};
`else
    exp_codes = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6};
`endif
    do_reset();
    bus.req = 8'h62;
    tick();
    bus.req = '0;
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.irq !== 1'b1 || bus.code !== exp_codes[k]) begin
        errors++; $display("FAIL rotate_%0d got irq=%b code=%0d exp 1 %0d", k, bus.irq, bus.code, exp_codes[k]);
      end
      // Ack and re-pend all three lines in the same cycle.
      bus.ack = 1'b1; bus.req = 8'h62;
      tick();
      bus.ack = 1'b0; bus.req = '0;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; bus.req = '0; bus.mask = '0; bus.ack = 1'b0;
    test_reset();
    test_single();
    test_mask();
    test_hold();
    test_collision();
    test_ack_idle();
    test_rotate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
